xalu: RTL and testbench
=======================

Name: xalu

Overview:
- Multi-cycle multiply/divide unit owning the HI/LO architectural registers of the pipelined MIPS CPU.
- Accepts one operation per issue: mult, multu, div, divu, mthi or mtlo.
- Raises Busy for a fixed latency so the pipeline can stall HI/LO consumers and new multiply/divide issues.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu.
- DIV_CYCLES, 10, Busy cycles for div/divu.

Ports:
- Clock   input  1   system clock, rising edge.
- Reset   input  1   asynchronous, active-low reset.
- Start   input  2   issue request; Start[0]=1 issues the op on XALUOp; Start[1] reserved, ignored.
- XALUOp  input  3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 see Optional Feature.
- Busy    output 1   1 while a mult/div is in flight.
- RD1     input  32  operand A (rs); dividend; mthi/mtlo source.
- RD2     input  32  operand B (rt); divisor.
- HI      output 32  HI register.
- LO      output 32  LO register.

Behaviour:
- Reset low, asynchronously: HI=0, LO=0, Busy=0, counter=0, pending result cleared.
- Issue: a rising edge with Start[0]=1 and Busy=0.
  - RD1, RD2 and XALUOp are sampled only at the issue edge; later changes have no effect.
- mult/multu issue:
  - 64-bit product computed from the latched operands (signed or unsigned).
  - Counter loaded with MULT_CYCLES; Busy=1 from the issue edge for exactly MULT_CYCLES cycles.
  - At the edge where the counter reaches 0: HI=product[63:32], LO=product[31:0], Busy falls.
  - HI/LO keep their old values while Busy=1.
- div/divu issue:
  - Same handshake with DIV_CYCLES.
  - LO = quotient, truncated toward zero.
  - HI = remainder, sign of dividend for div.
  - divu treats both operands as unsigned.
- Divide by zero: Busy still runs DIV_CYCLES; HI and LO are left unchanged.
- div overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- mthi/mtlo issue: HI (or LO) = RD1 at the issue edge; Busy stays 0; the unit can issue again next cycle.
- Start[0]=1 while Busy=1: ignored. No queuing, no abort; the pipeline must stall the issue.
- XALUOp 6/7 with the feature disabled: no-op.
- Reset low mid-operation: the operation is aborted, Busy=0, HI=LO=0.
- Outputs HI, LO and Busy are registered; no combinational path from inputs.

Optional Feature:
- Macro XALU_MADD_EN.
- When defined:
  - XALUOp 6 = madd: {HI,LO} += signed RD1*RD2.
  - XALUOp 7 = maddu: unsigned variant.
  - Both use MULT_CYCLES latency and 64-bit wrap-around accumulate on the HI/LO values current at the completion edge.
- When undefined: ops 6/7 are ignored (no Busy, no HI/LO change).

Decomposition:
- Package xalu_pkg holds:
  - 3-bit op-code constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU).
  - Default latency constants.
- Single module; no sub-module needed. Arithmetic is done with behavioural operators at issue into a pending-result register, released by a down-counter.

Test Plan:
- mult RD1=-7, RD2=13 for one cycle, then RD1/RD2 changed:
  - Busy=1 for 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFA5.
  - Operands changed after issue do not affect the result.
- mult -7 * -10 -> HI=0, LO=70.
- multu with the same 32-bit operands:
  - 0xFFFFFFF9 * 13 -> HI=0x0000000C, LO=0xFFFFFFA5.
  - 1937298193 * 1201019822 -> {HI,LO} equals the exact 64-bit product.
- div cases (each holds Busy for 10 cycles):
  - 8/3 -> LO=2, HI=2.
  - -8/3 -> LO=0xFFFFFFFE, HI=0xFFFFFFFE.
  - 8/-3 -> LO=0xFFFFFFFE, HI=2.
  - 5/0 -> HI/LO unchanged.
- divu cases:
  - 0xFFFFFFF8/3 -> LO=0x55555552, HI=2.
  - 0xFFFFFFF8/0xFFFFFF3A -> LO=1, HI=0xBE.
- mthi RD1=100, then mtlo RD1=300 on consecutive cycles:
  - HI=100, LO=300, Busy never rises.
  - A Start during Busy is ignored.
  - Asserting Reset low mid-div clears HI, LO and Busy immediately.

Source files
------------

// File: rtl/xalu_pkg.sv
// Shared constants for the xalu multiply/divide unit: op-codes, default
// latencies and the small control FSM state type.
package xalu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } xalu_state_e;

endpackage

// File: rtl/xalu.sv
// xalu: multi-cycle multiply/divide unit owning the HI/LO registers.
// The arithmetic is evaluated behaviourally at issue into a pending-result
// register; a down-counter releases it into HI/LO after the fixed latency.
// Optional build macro XALU_MADD_EN enables madd/maddu (ops 6/7).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no operation in flight; issues accepted, mthi/mtlo write here
// ST_BUSY | mult/div/madd in flight; counter running, issues ignored
module xalu
    import xalu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  Start,
    input  logic [2:0]  XALUOp,
    output logic        Busy,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    xalu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_wr_q, pend_wr_d;
    logic             pend_acc_q, pend_acc_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             busy;
    logic             done;
    logic             issue;
    logic             is_mul, is_div, is_madd, is_long;
    logic [63:0]      prod_s, prod_u;
    logic signed [31:0] sa, sb;
    logic [31:0]      quot, rem;
    logic             div_ovf;
    logic             start_unused;

    // Start[1] is reserved and deliberately has no effect
    assign start_unused = Start[1];

    // Op decode for the issue cycle
    always_comb begin
        issue  = Start[0] && (state_q == ST_IDLE);
        is_mul = (XALUOp == OP_MULT) || (XALUOp == OP_MULTU);
        is_div = (XALUOp == OP_DIV)  || (XALUOp == OP_DIVU);
`ifdef XALU_MADD_EN
        is_madd = (XALUOp == OP_MADD) || (XALUOp == OP_MADDU);
`else
        is_madd = 1'b0;
`endif
        is_long = is_mul || is_div || is_madd;
    end

    // Behavioural arithmetic on the issue-cycle operands
    always_comb begin
        sa      = RD1;
        sb      = RD2;
        prod_s  = $signed({{32{RD1[31]}}, RD1}) * $signed({{32{RD2[31]}}, RD2});
        prod_u  = {32'b0, RD1} * {32'b0, RD2};
        // 0x80000000 / -1 overflows 32 bits; pin the architectural result
        div_ovf = (RD1 == 32'h8000_0000) && (RD2 == 32'hFFFF_FFFF);
        quot    = 32'b0;
        rem     = 32'b0;
        if (RD2 != 32'b0) begin
            if (XALUOp == OP_DIVU) begin
                quot = RD1 / RD2;
                rem  = RD1 % RD2;
            end else if (div_ovf) begin
                quot = 32'h8000_0000;
                rem  = 32'b0;
            end else begin
                quot = sa / sb;
                rem  = sa % sb;
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue && is_long)      state_d = ST_BUSY;
            ST_BUSY: if (cnt_q <= CNT_W'(1))    state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == ST_BUSY);
        done = busy && (cnt_q <= CNT_W'(1));
    end

    // Datapath next-state: counter, pending result and HI/LO updates
    always_comb begin
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_wr_d  = pend_wr_q;
        pend_acc_d = pend_acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (done && pend_wr_q) begin
                if (pend_acc_q) {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
                else            {hi_d, lo_d} = pend_q;
            end
        end else if (issue) begin
            pend_acc_d = 1'b0;
            pend_wr_d  = 1'b1;
            case (XALUOp)
                OP_MULT: begin
                    cnt_d  = CNT_W'(MULT_CYCLES);
                    pend_d = prod_s;
                end
                OP_MULTU: begin
                    cnt_d  = CNT_W'(MULT_CYCLES);
                    pend_d = prod_u;
                end
                OP_DIV, OP_DIVU: begin
                    cnt_d     = CNT_W'(DIV_CYCLES);
                    pend_d    = {rem, quot};
                    pend_wr_d = (RD2 != 32'b0);
                end
                OP_MTHI: hi_d = RD1;
                OP_MTLO: lo_d = RD1;
`ifdef XALU_MADD_EN
                OP_MADD: begin
                    cnt_d      = CNT_W'(MULT_CYCLES);
                    pend_d     = prod_s;
                    pend_acc_d = 1'b1;
                end
                OP_MADDU: begin
                    cnt_d      = CNT_W'(MULT_CYCLES);
                    pend_d     = prod_u;
                    pend_acc_d = 1'b1;
                end
`endif
                default: pend_wr_d = pend_wr_q;
            endcase
        end
    end

    // Datapath registers; reset aborts any operation in flight
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_wr_q  <= 1'b0;
            pend_acc_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_wr_q  <= pend_wr_d;
            pend_acc_q <= pend_acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign Busy = busy;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_xalu.sv
// Self-checking bench for xalu: directed vector table, hand-written
// corner sequences, and random ops against a 64-bit arithmetic model.
module tb_xalu;
    import xalu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  Start = 2'b00;
    logic [2:0]  XALUOp = 3'd0;
    logic        Busy;
    logic [31:0] RD1 = '0, RD2 = '0;
    logic [31:0] HI, LO;

    xalu dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .XALUOp(XALUOp),
        .Busy  (Busy),
        .RD1   (RD1),
        .RD2   (RD2),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] ref_hi = '0, ref_lo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t tbl[16];
    int   n_tbl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Architectural model: results from plain 64-bit arithmetic
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo, output int cyc);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        cyc = 0;
        case (op)
            OP_MULT:  begin p = sa * sb; {hi, lo} = p; cyc = 5; end
            OP_MULTU: begin p = ua * ub; {hi, lo} = p; cyc = 5; end
            OP_DIV: begin
                cyc = 10;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end
            end
            OP_DIVU: begin
                cyc = 10;
                if (b != 0) begin
                    p = ua / ub; lo = p[31:0];
                    p = ua % ub; hi = p[31:0];
                end
            end
            OP_MTHI: hi = a;
            OP_MTLO: lo = a;
`ifdef XALU_MADD_EN
            OP_MADD:  begin p = sa * sb; {hi, lo} = {hi, lo} + p; cyc = 5; end
            OP_MADDU: begin p = ua * ub; {hi, lo} = {hi, lo} + p; cyc = 5; end
`endif
            default: cyc = 0;
        endcase
    endtask

    // Issue one op (called at posedge+1), scramble inputs after issue,
    // then check Busy length, HI/LO hold while busy, and final HI/LO.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int ecyc);
        int c;
        logic [31:0] old_hi, old_lo;
        old_hi = ref_hi;
        old_lo = ref_lo;
        Start  = {1'($urandom_range(0, 1)), 1'b1};
        XALUOp = op;
        RD1    = a;
        RD2    = b;
        @(posedge Clock); #1;
        Start  = 2'b00;
        XALUOp = 3'($urandom);
        RD1    = $urandom;
        RD2    = $urandom;
        if (ecyc > 0) check({name, "_hold"}, {HI, LO}, {old_hi, old_lo});
        c = 0;
        while (Busy && c < 40) begin
            c++;
            @(posedge Clock); #1;
        end
        check({name, "_busy_cycles"}, 64'(c), 64'(ecyc));
        check({name, "_hilo"}, {HI, LO}, {ehi, elo});
        ref_hi = ehi;
        ref_lo = elo;
    endtask

    initial begin
        logic [63:0] big;
        logic [31:0] mh, ml, ra, rb;
        logic [2:0]  rop;
        int ecyc, c;

        // reset state
        repeat (2) @(posedge Clock);
        #1;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        Reset = 1'b1;
        @(posedge Clock); #1;

        // directed vector table
        big = 64'd1937298193 * 64'd1201019822;
        tbl[0]  = '{OP_MULT,  32'hFFFF_FFF9, 32'd13,       32'hFFFF_FFFF, 32'hFFFF_FFA5, 5};
        tbl[1]  = '{OP_MULT,  32'hFFFF_FFF9, 32'hFFFF_FFF6, 32'd0,        32'd70,        5};
        tbl[2]  = '{OP_MULTU, 32'hFFFF_FFF9, 32'd13,       32'h0000_000C, 32'hFFFF_FFA5, 5};
        tbl[3]  = '{OP_MULTU, 32'd1937298193, 32'd1201019822, big[63:32], big[31:0],    5};
        tbl[4]  = '{OP_DIV,   32'd8,         32'd3,        32'd2,         32'd2,         10};
        tbl[5]  = '{OP_DIV,   32'hFFFF_FFF8, 32'd3,        32'hFFFF_FFFE, 32'hFFFF_FFFE, 10};
        tbl[6]  = '{OP_DIV,   32'd8,         32'hFFFF_FFFD, 32'd2,        32'hFFFF_FFFE, 10};
        tbl[7]  = '{OP_DIV,   32'd5,         32'd0,        32'd2,         32'hFFFF_FFFE, 10};
        tbl[8]  = '{OP_DIVU,  32'hFFFF_FFF8, 32'd3,        32'd2,         32'h5555_5552, 10};
        tbl[9]  = '{OP_DIVU,  32'hFFFF_FFF8, 32'hFFFF_FF3A, 32'h0000_00BE, 32'd1,       10};
        tbl[10] = '{OP_DIVU,  32'd77,        32'd0,        32'h0000_00BE, 32'd1,         10};
        tbl[11] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10};
        tbl[12] = '{OP_MTHI,  32'd100,       32'd9,        32'd100,       32'h8000_0000, 0};
        tbl[13] = '{OP_MTLO,  32'd300,       32'd9,        32'd100,       32'd300,       0};
`ifdef XALU_MADD_EN
        tbl[14] = '{OP_MADD,  32'd5,         32'd7,        32'd100,       32'd335,       5};
        tbl[15] = '{OP_MADDU, 32'hFFFF_FFFF, 32'd2,        32'd102,       32'd333,       5};
`else
        tbl[14] = '{OP_MADD,  32'd5,         32'd7,        32'd100,       32'd300,       0};
        tbl[15] = '{OP_MADDU, 32'hFFFF_FFFF, 32'd2,        32'd100,       32'd300,       0};
`endif
        n_tbl = 16;
        for (int i = 0; i < n_tbl; i++)
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].hi, tbl[i].lo, tbl[i].cyc);

        // Start during Busy is ignored: mult 3*4 with an mthi attempt mid-flight
        Start = 2'b01; XALUOp = OP_MULT; RD1 = 32'd3; RD2 = 32'd4;
        @(posedge Clock); #1;
        Start = 2'b00;
        c = 0;
        while (Busy && c < 40) begin
            c++;
            if (c == 2) begin
                Start = 2'b01; XALUOp = OP_MTHI; RD1 = 32'hDEAD_BEEF;
            end
            @(posedge Clock); #1;
            if (c == 2) Start = 2'b00;
        end
        check("ignore_busy_cycles", 64'(c), 64'd5);
        check("ignore_busy_hilo", {HI, LO}, {32'd0, 32'd12});
        ref_hi = 32'd0;
        ref_lo = 32'd12;

        // random ops against the model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end
            mh = ref_hi;
            ml = ref_lo;
            model(rop, ra, rb, mh, ml, ecyc);
            do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, mh, ml, ecyc);
        end

        // asynchronous reset in the middle of a divide
        Start = 2'b01; XALUOp = OP_DIV; RD1 = 32'd100; RD2 = 32'd7;
        @(posedge Clock); #1;
        Start = 2'b00;
        repeat (3) @(posedge Clock);
        #1;
        check("middiv_busy", 64'(Busy), 64'd1);
        Reset = 1'b0;
        #1;
        check("rst_mid_busy", 64'(Busy), 64'd0);
        check("rst_mid_hilo", {HI, LO}, 64'd0);
        #2;
        Reset = 1'b1;
        repeat (12) @(posedge Clock);
        #1;
        check("post_rst_busy", 64'(Busy), 64'd0);
        check("post_rst_hilo", {HI, LO}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
